// File: rtl/cfa_pkg.sv
// Shared types and constants for the CFLog writer: FSM encoding, record sizes,
// marker/exit words and the event record carried through the event FIFO.
package cfa_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SRC,
        S_WR_DST,
        S_WR_MARK,
        S_WR_CHI,
        S_WR_CLO,
        S_UPD_CHI,
        S_UPD_CLO,
        S_FLUSH
    } wr_state_e;

    localparam int unsigned BRANCH_WORDS = 2;
    localparam int unsigned LOOP_WORDS   = 3;

    localparam logic [15:0] LOOP_MARK_DEF = 16'hffff;
    localparam logic [15:0] TCB_EXIT_DEF  = 16'hdffe;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dest;
        logic        loop_flag;
        logic [31:0] ctr;
    } cfa_evt_t;

    localparam int unsigned EVT_W = $bits(cfa_evt_t);

    // Byte address of a 16-bit log word.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
        return base + (idx << 1);
    endfunction

endpackage

// File: rtl/cflog_evt_fifo.sv
// Synchronous event FIFO with show-ahead read data; a push while full is dropped
// and a clear discards everything, including a same-cycle push.
module cflog_evt_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    // NOTE: storage has no reset; the count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cflog_writer.sv
// Serialises control-flow events into the CFLog as 16-bit words: branch pairs,
// in-place loop counter records, and flush handshaking with the TCB.
module cflog_writer
    import cfa_pkg::*;
#(
    parameter logic [15:0] LOG_BASE   = 16'he000,
    parameter int unsigned LOG_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] TCB_EXIT   = TCB_EXIT_DEF,
    parameter logic [15:0] LOOP_MARK  = LOOP_MARK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hw_wr_en,
    input  logic [15:0] prev_pc,
    input  logic [15:0] pc,
    input  logic [15:0] loop_detect,
    input  logic [31:0] loop_ctr,
    output logic        log_wr_en,
    output logic [15:0] log_addr,
    output logic [15:0] log_wdata,
    output logic [15:0] log_ptr,
    output logic        flush_req,
    output logic        ovf
);

    localparam logic [16:0] CAP = 17'(LOG_WORDS);

    cfa_evt_t    w_push_evt, w_head;
    wr_state_e   r_state, w_state_nxt, w_disp_state;
    logic        w_full, w_empty, w_pop, w_clear, w_dispatch;
    logic [15:0] r_ptr, w_ptr_nxt, r_rec_addr, w_rec_addr_nxt, w_disp_rec_addr;
    logic [15:0] w_idx, w_disp_idx, w_wdata, w_disp_wdata, r_dest, w_dest_nxt;
    logic [31:0] r_ctr, w_ctr_nxt;
    logic        r_rec_open, w_rec_open_nxt, w_disp_rec_open;
    logic        w_wr_en, w_disp_wr_en;
    logic        r_wr_en, r_flush_req, r_ovf;
    logic [15:0] r_addr, r_wdata;

    assign w_push_evt = '{src: prev_pc, dest: pc, loop_flag: |loop_detect, ctr: loop_ctr};

    cflog_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (hw_wr_en),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_wdata (w_push_evt),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // What the head event turns into if popped now; an event that does not fit goes to FLUSH.
    always_comb begin
        w_disp_state    = S_FLUSH;
        w_disp_wr_en    = 1'b0;
        w_disp_idx      = r_ptr;
        w_disp_wdata    = 16'h0000;
        w_disp_rec_open = r_rec_open;
        w_disp_rec_addr = r_rec_addr;
        if (!w_head.loop_flag) begin
            w_disp_rec_open = 1'b0;
            if ({1'b0, r_ptr} + 17'(BRANCH_WORDS) <= CAP) begin
                w_disp_state = S_WR_SRC;
                w_disp_wr_en = 1'b1;
                w_disp_wdata = w_head.src;
            end
        end else if (r_rec_open) begin
            w_disp_state = S_UPD_CHI;
            w_disp_wr_en = 1'b1;
            w_disp_idx   = r_rec_addr;
            w_disp_wdata = w_head.ctr[31:16];
        end else if ({1'b0, r_ptr} + 17'(LOOP_WORDS) <= CAP) begin
            w_disp_state    = S_WR_MARK;
            w_disp_wr_en    = 1'b1;
            w_disp_wdata    = LOOP_MARK;
            w_disp_rec_open = 1'b1;
            w_disp_rec_addr = r_ptr + 16'd1;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_clear        = 1'b0;
        w_dispatch     = 1'b0;
        w_wr_en        = 1'b0;
        w_idx          = r_ptr;
        w_wdata        = 16'h0000;
        w_ptr_nxt      = r_ptr;
        w_rec_open_nxt = r_rec_open;
        w_rec_addr_nxt = r_rec_addr;
        w_dest_nxt     = r_dest;
        w_ctr_nxt      = r_ctr;
        case (r_state)
            S_IDLE: begin
                if (r_ovf) w_state_nxt = S_FLUSH;
                else       w_dispatch  = !w_empty;
            end
            S_WR_SRC: begin
                w_state_nxt = S_WR_DST;
                w_wr_en     = 1'b1;
                w_idx       = r_ptr + 16'd1;
                w_wdata     = r_dest;
                w_ptr_nxt   = r_ptr + 16'(BRANCH_WORDS);
            end
            S_WR_MARK: begin
                w_state_nxt = S_WR_CHI;
                w_wr_en     = 1'b1;
                w_idx       = r_ptr + 16'd1;
                w_wdata     = r_ctr[31:16];
            end
            S_WR_CHI: begin
                w_state_nxt = S_WR_CLO;
                w_wr_en     = 1'b1;
                w_idx       = r_ptr + 16'd2;
                w_wdata     = r_ctr[15:0];
                w_ptr_nxt   = r_ptr + 16'(LOOP_WORDS);
            end
            S_UPD_CHI: begin
                w_state_nxt = S_UPD_CLO;
                w_wr_en     = 1'b1;
                w_idx       = r_rec_addr + 16'd1;
                w_wdata     = r_ctr[15:0];
            end
            // Last word of a record: chain straight into the next event to keep one word per cycle.
            S_WR_DST, S_WR_CLO, S_UPD_CLO: begin
                if (w_empty) w_state_nxt = S_IDLE;
                else         w_dispatch  = 1'b1;
            end
            S_FLUSH: begin
                if (pc == TCB_EXIT) begin
                    w_state_nxt    = S_IDLE;
                    w_clear        = 1'b1;
                    w_ptr_nxt      = 16'h0000;
                    w_rec_open_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_dispatch) begin
            w_pop          = 1'b1;
            w_state_nxt    = w_disp_state;
            w_wr_en        = w_disp_wr_en;
            w_idx          = w_disp_idx;
            w_wdata        = w_disp_wdata;
            w_rec_open_nxt = w_disp_rec_open;
            w_rec_addr_nxt = w_disp_rec_addr;
            w_dest_nxt     = w_head.dest;
            w_ctr_nxt      = w_head.ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= 16'h0000;
            r_rec_open  <= 1'b0;
            r_rec_addr  <= 16'h0000;
            r_dest      <= 16'h0000;
            r_ctr       <= 32'h0;
            r_wr_en     <= 1'b0;
            r_addr      <= LOG_BASE;
            r_wdata     <= 16'h0000;
            r_flush_req <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rec_open  <= w_rec_open_nxt;
            r_rec_addr  <= w_rec_addr_nxt;
            r_dest      <= w_dest_nxt;
            r_ctr       <= w_ctr_nxt;
            r_wr_en     <= w_wr_en;
            r_flush_req <= (w_state_nxt == S_FLUSH);
            if (w_wr_en) begin
                r_addr  <= word_addr(LOG_BASE, w_idx);
                r_wdata <= w_wdata;
            end
            if (w_clear)               r_ovf <= 1'b0;
            else if (hw_wr_en && w_full) r_ovf <= 1'b1;
        end
    end

    assign log_wr_en = r_wr_en;
    assign log_addr  = r_addr;
    assign log_wdata = r_wdata;
    assign log_ptr   = r_ptr;
    assign flush_req = r_flush_req;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer: directed scenarios plus randomized events
// compared against a word-level model of the CFLog contents and pointer.
module tb_cflog_writer;

    localparam int          LW   = 16;
    localparam logic [15:0] BASE = 16'he000;
    localparam logic [15:0] EXIT = 16'hdffe;
    localparam logic [15:0] MARK = 16'hffff;

    logic        clk, reset, hw_wr_en;
    logic [15:0] prev_pc, pc, loop_detect;
    logic [31:0] loop_ctr;
    logic        log_wr_en, flush_req, ovf;
    logic [15:0] log_addr, log_wdata, log_ptr;

    cflog_writer #(
        .LOG_BASE   (BASE),
        .LOG_WORDS  (LW),
        .FIFO_DEPTH (4),
        .TCB_EXIT   (EXIT),
        .LOOP_MARK  (MARK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hw_wr_en    (hw_wr_en),
        .prev_pc     (prev_pc),
        .pc          (pc),
        .loop_detect (loop_detect),
        .loop_ctr    (loop_ctr),
        .log_wr_en   (log_wr_en),
        .log_addr    (log_addr),
        .log_wdata   (log_wdata),
        .log_ptr     (log_ptr),
        .flush_req   (flush_req),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: log image, next free word, open loop record.
    logic [15:0] m_mem [LW];
    int          m_ptr;
    bit          m_open;
    int          m_rec;

    // Observed log image built from the write port.
    logic [15:0] cap_mem [LW];
    int          n_writes = 0;
    int          n_bad_addr = 0;
    int          mon_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (log_wr_en === 1'b1) begin
            n_writes++;
            mon_idx = int'(log_addr - BASE) / 2;
            if (log_addr[0] || mon_idx >= LW) n_bad_addr++;
            else cap_mem[mon_idx] = log_wdata;
        end
    end

    // Returns number of words the event writes, or -1 when it forces a flush.
    function automatic int model_event(input logic [15:0] src, input logic [15:0] dst,
                                       input bit lp, input logic [31:0] ctr);
        if (!lp) begin
            m_open = 0;
            if (m_ptr + 2 > LW) return -1;
            m_mem[m_ptr]     = src;
            m_mem[m_ptr + 1] = dst;
            m_ptr += 2;
            return 2;
        end
        if (m_open) begin
            m_mem[m_rec]     = ctr[31:16];
            m_mem[m_rec + 1] = ctr[15:0];
            return 2;
        end
        if (m_ptr + 3 > LW) return -1;
        m_mem[m_ptr]     = MARK;
        m_mem[m_ptr + 1] = ctr[31:16];
        m_mem[m_ptr + 2] = ctr[15:0];
        m_rec  = m_ptr + 1;
        m_open = 1;
        m_ptr += 3;
        return 3;
    endfunction

    function automatic logic [15:0] rand_pc();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == EXIT) v = 16'h1234;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_models();
        for (int i = 0; i < LW; i++) begin
            m_mem[i]   = 16'h0;
            cap_mem[i] = 16'h0;
        end
        m_ptr  = 0;
        m_open = 0;
        m_rec  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hw_wr_en = 1'b0;
        pc = 16'h0;
        tick(2);
        reset = 1'b0;
        clear_models();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".wr_en"}, log_wr_en, 1'b0);
        check({tag, ".addr"},  log_addr,  BASE);
        check({tag, ".wdata"}, log_wdata, 16'h0);
        check({tag, ".ptr"},   log_ptr,   16'h0);
        check({tag, ".flush"}, flush_req, 1'b0);
        check({tag, ".ovf"},   ovf,       1'b0);
    endtask

    task automatic drive_evt(input logic [15:0] src, input logic [15:0] dst,
                             input bit lp, input logic [31:0] ctr);
        logic [15:0] ld;
        ld = 16'($urandom);
        if (ld == 16'h0) ld = 16'h0100;
        hw_wr_en    = 1'b1;
        prev_pc     = src;
        pc          = dst;
        loop_detect = lp ? ld : 16'h0;
        loop_ctr    = ctr;
    endtask

    // One-cycle strobe; returns at the falling edge after the push edge.
    task automatic strobe(input logic [15:0] src, input logic [15:0] dst,
                          input bit lp, input logic [31:0] ctr);
        drive_evt(src, dst, lp, ctr);
        @(negedge clk);
        hw_wr_en    = 1'b0;
        pc          = 16'h0;
        loop_detect = 16'h0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < LW; i++)
            check($sformatf("%s.mem[%0d]", tag, i), cap_mem[i], m_mem[i]);
    endtask

    task automatic flush_exit(input bit with_evt);
        int w0;
        w0 = n_writes;
        strobe(rand_pc(), rand_pc(), bit'($urandom_range(1, 0)), $urandom);
        tick(2);
        check("flush.hold", flush_req, 1'b1);
        pc       = EXIT;
        hw_wr_en = with_evt;
        prev_pc  = rand_pc();
        @(negedge clk);
        hw_wr_en = 1'b0;
        pc       = 16'h0;
        check("flush.exit_req", flush_req, 1'b0);
        check("flush.exit_ptr", log_ptr, 16'h0);
        check("flush.exit_ovf", ovf, 1'b0);
        m_ptr  = 0;
        m_open = 0;
        tick(6);
        check("flush.no_writes", n_writes - w0, 0);
    endtask

    task automatic send(input logic [15:0] src, input logic [15:0] dst,
                        input bit lp, input logic [31:0] ctr);
        int exp_wr, w0;
        exp_wr = model_event(src, dst, lp, ctr);
        w0 = n_writes;
        strobe(src, dst, lp, ctr);
        tick(6);
        check("send.nwr",   n_writes - w0, (exp_wr < 0) ? 0 : exp_wr);
        check("send.ptr",   log_ptr, 16'(m_ptr));
        check("send.flush", flush_req, (exp_wr < 0) ? 1'b1 : 1'b0);
        if (exp_wr < 0) flush_exit(bit'($urandom_range(1, 0)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        int nw;
        logic [31:0] c [8];
        reset = 1'b1; hw_wr_en = 1'b0; prev_pc = 16'h0; pc = 16'h0;
        loop_detect = 16'h0; loop_ctr = 32'h0;

        // Reset values and first-write latency for a branch.
        do_reset();
        check_reset_outputs("rst");
        nw = model_event(16'h1000, 16'h1200, 0, 32'h0);
        strobe(16'h1000, 16'h1200, 0, 32'h0);
        check("lat.push_cycle_wr", log_wr_en, 1'b0);
        @(negedge clk);
        check("lat.src_wr", log_wr_en, 1'b1);
        check("lat.src_addr", log_addr, BASE);
        check("lat.src_data", log_wdata, 16'h1000);
        check("lat.src_ptr", log_ptr, 16'h0);
        @(negedge clk);
        check("lat.dst_wr", log_wr_en, 1'b1);
        check("lat.dst_addr", log_addr, BASE + 16'd2);
        check("lat.dst_data", log_wdata, 16'h1200);
        check("lat.dst_ptr", log_ptr, 16'(nw));
        @(negedge clk);
        check("lat.idle_wr", log_wr_en, 1'b0);

        // Loop compression, then a branch closing the record, then a fresh record.
        do_reset();
        send(16'h2000, 16'h2010, 1, 32'd3);
        check("loop.mark", cap_mem[0], 16'hffff);
        check("loop.chi",  cap_mem[1], 16'h0000);
        check("loop.clo",  cap_mem[2], 16'h0003);
        send(16'h2000, 16'h2010, 1, 32'd4);
        check("loop.upd4", cap_mem[2], 16'h0004);
        send(16'h2000, 16'h2010, 1, 32'd5);
        check("loop.upd5", cap_mem[2], 16'h0005);
        check("loop.ptr",  log_ptr, 16'd3);
        send(16'h3000, 16'h3400, 0, 32'h0);
        check("loop.br_src", cap_mem[3], 16'h3000);
        send(16'h2000, 16'h2010, 1, 32'h0007_0008);
        check("loop.new_mark", cap_mem[5], 16'hffff);
        check("loop.new_chi",  cap_mem[6], 16'h0007);
        check_mem("loop");

        // Capacity boundary: pointer at LW-1 forces a flush on a branch.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(rand_pc(), rand_pc(), 1, $urandom);
            send(rand_pc(), rand_pc(), 0, 32'h0);
        end
        check("cap.ptr15", log_ptr, 16'd15);
        send(16'h4000, 16'h4100, 0, 32'h0);
        send(16'h5000, 16'h5100, 0, 32'h0);
        check("cap.after_flush", cap_mem[0], 16'h5000);
        check_mem("cap");

        // Exact fit: eight branches fill the log, a loop event then flushes.
        do_reset();
        for (int i = 0; i < 8; i++) send(rand_pc(), rand_pc(), 0, 32'h0);
        check("fit.full_ptr", log_ptr, 16'd16);
        send(rand_pc(), rand_pc(), 1, $urandom);
        check_mem("fit");

        // Overflow: back-to-back counter updates outrun the 2-cycle drain rate.
        do_reset();
        send(16'h6000, 16'h6010, 1, 32'h0001_0001);
        for (int i = 0; i < 8; i++) c[i] = $urandom;
        w0 = n_writes;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("ovf.before_drop", ovf, 1'b0);
            drive_evt(16'h6000, 16'h6010, 1, c[i]);
            @(negedge clk);
        end
        hw_wr_en = 1'b0; pc = 16'h0; loop_detect = 16'h0;
        for (int i = 0; i < 7; i++) nw = model_event(16'h6000, 16'h6010, 1, c[i]);
        check("ovf.set", ovf, 1'b1);
        check("ovf.draining", flush_req, 1'b0);
        tick(12);
        check("ovf.flush_req", flush_req, 1'b1);
        check("ovf.sticky", ovf, 1'b1);
        check("ovf.nwr", n_writes - w0, 14);
        check("ovf.last_hi", cap_mem[1], c[6][31:16]);
        check("ovf.last_lo", cap_mem[2], c[6][15:0]);
        check("ovf.ptr", log_ptr, 16'd3);
        flush_exit(1'b0);
        check_mem("ovf");

        // Reset while the counter-high word of a new record is on the bus.
        do_reset();
        send(16'h7000, 16'h7100, 0, 32'h0);
        strobe(16'h7200, 16'h7300, 1, 32'hABCD_1234);
        @(negedge clk);
        @(negedge clk);
        check("mid.chi_wr", log_wr_en, 1'b1);
        check("mid.chi_data", log_wdata, 16'hABCD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid");
        clear_models();
        send(16'h7400, 16'h7500, 0, 32'h0);
        check("mid.word0", cap_mem[0], 16'h7400);
        check_mem("mid");

        // Randomized event stream against the model.
        do_reset();
        for (int i = 0; i < 80; i++)
            send(rand_pc(), rand_pc(), ($urandom_range(99, 0) < 55), $urandom);
        check_mem("rand");
        check("addr.range", n_bad_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
